// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, horizontal/vertical phase FSMs,
// registered enable/sync/frame_start aligned with the counters, and a sync delay line.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk_in,
    input  logic       reset_in,
    output logic [9:0] current_row,
    output logic [9:0] current_line,
    output logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int SD_W    = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

    localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST_ACT  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_LAST_FRT  = 10'(H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] H_LAST_SYN  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_ACT  = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_LAST_FRT  = 10'(V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] V_LAST_SYN  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    logic [4:0]      div_q, div_d;
    logic [9:0]      h_q, h_d, v_q, v_d;
    logic [1:0]      hst_q, hst_d, vst_q, vst_d;
    logic            en_q, en_d;
    logic            hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic            fs_q, fs_d;
    logic [SD_W-1:0] hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic            line_end_s;

    // A phase is left when the counter sits on that phase's last value as it advances.
    function automatic logic [1:0] next_phase(
        input logic [1:0] st,
        input logic [9:0] cnt,
        input logic [9:0] last_act,
        input logic [9:0] last_frt,
        input logic [9:0] last_syn,
        input logic [9:0] last_all
    );
        logic [1:0] nxt;
        case (st)
            ST_ACTIVE: nxt = (cnt == last_act) ? ST_FRONT  : ST_ACTIVE;
            ST_FRONT:  nxt = (cnt == last_frt) ? ST_SYNC   : ST_FRONT;
            ST_SYNC:   nxt = (cnt == last_syn) ? ST_BACK   : ST_SYNC;
            ST_BACK:   nxt = (cnt == last_all) ? ST_ACTIVE : ST_BACK;
            default:   nxt = ST_ACTIVE;
        endcase
        return nxt;
    endfunction

    // Next-state logic: divider, counters, phases and the counter-aligned decodes.
    always_comb begin
        pixel_tick = (div_q == DIV_LAST);
        div_d      = pixel_tick ? 5'd0 : div_q + 5'd1;
        line_end_s = pixel_tick && (h_q == H_LAST);

        if (pixel_tick) begin
            h_d   = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
            hst_d = next_phase(hst_q, h_q, H_LAST_ACT, H_LAST_FRT, H_LAST_SYN, H_LAST);
        end else begin
            h_d   = h_q;
            hst_d = hst_q;
        end

        if (line_end_s) begin
            v_d   = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            vst_d = next_phase(vst_q, v_q, V_LAST_ACT, V_LAST_FRT, V_LAST_SYN, V_LAST);
        end else begin
            v_d   = v_q;
            vst_d = vst_q;
        end

        en_d     = (hst_d == ST_ACTIVE) && (vst_d == ST_ACTIVE);
        hs_raw_d = (hst_d != ST_SYNC);
        vs_raw_d = (vst_d != ST_SYNC);
        fs_d     = pixel_tick && (h_d == 10'd0) && (v_d == 10'd0);

        hs_sr_d[0] = hs_raw_q;
        vs_sr_d[0] = vs_raw_q;
        for (int i = 1; i < SD_W; i++) begin
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end
    end

    // State registers; reset parks the raster on the last pixel so the first tick lands on (0,0).
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div_q    <= 5'd0;
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            hst_q    <= ST_BACK;
            vst_q    <= ST_BACK;
            en_q     <= 1'b0;
            hs_raw_q <= 1'b1;
            vs_raw_q <= 1'b1;
            fs_q     <= 1'b0;
            hs_sr_q  <= '1;
            vs_sr_q  <= '1;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hst_q    <= hst_d;
            vst_q    <= vst_d;
            en_q     <= en_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
            fs_q     <= fs_d;
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
        end
    end

    assign current_row  = h_q;
    assign current_line = v_q;
    assign enable       = en_q;
    assign frame_start  = fs_q;
    assign hsync        = (SYNC_DELAY == 0) ? hs_raw_q : hs_sr_q[SD_W-1];
    assign vsync        = (SYNC_DELAY == 0) ? vs_raw_q : vs_sr_q[SD_W-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a tiny-raster CLK_DIV=1/SYNC_DELAY=0
// instance, both checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        int cdiv; int sd;
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } geo_t;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] line;
        logic       en;
        logic       hs;
        logic       vs;
        logic       tick;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [9:0] row_a, line_a, row_b, line_b;
    logic       en_a, hs_a, vs_a, tick_a, fs_a;
    logic       en_b, hs_b, vs_b, tick_b, fs_b;

    exp_t qa[$];
    exp_t qb[$];
    geo_t ga, gb;
    int   na = 0, nb = 0;
    int   n_cmp = 0, n_bad = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk_in(clk), .reset_in(rst_a),
        .current_row(row_a), .current_line(line_a), .enable(en_a),
        .hsync(hs_a), .vsync(vs_a), .pixel_tick(tick_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .SYNC_DELAY(0),
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_b (
        .clk_in(clk), .reset_in(rst_b),
        .current_row(row_b), .current_line(line_b), .enable(en_b),
        .hsync(hs_b), .vsync(vs_b), .pixel_tick(tick_b), .frame_start(fs_b)
    );

    // Sync level n clocks after reset release (n < 0 means still in reset history).
    function automatic bit raw_sync(input int n, input geo_t g, input bit vert);
        int htot, vtot, t, pos, row, line;
        htot = g.hv + g.hf + g.hs + g.hb;
        vtot = g.vv + g.vf + g.vs + g.vb;
        if (n < 0) return 1'b1;
        t = n / g.cdiv;
        if (t == 0) return 1'b1;
        pos  = (t - 1) % (htot * vtot);
        row  = pos % htot;
        line = pos / htot;
        if (vert) return !(line >= g.vv + g.vf && line < g.vv + g.vf + g.vs);
        return !(row >= g.hv + g.hf && row < g.hv + g.hf + g.hs);
    endfunction

    function automatic exp_t ref_model(input int n, input geo_t g);
        exp_t e;
        int   htot, vtot, t, pos, row, line;
        htot = g.hv + g.hf + g.hs + g.hb;
        vtot = g.vv + g.vf + g.vs + g.vb;
        t    = n / g.cdiv;
        if (t == 0) begin
            row = htot - 1; line = vtot - 1; pos = -1;
        end else begin
            pos  = (t - 1) % (htot * vtot);
            row  = pos % htot;
            line = pos / htot;
        end
        e.row  = 10'(row);
        e.line = 10'(line);
        e.en   = (t > 0) && (row < g.hv) && (line < g.vv);
        e.tick = ((n % g.cdiv) == g.cdiv - 1);
        e.fs   = (pos == 0) && ((n % g.cdiv) == 0);
        e.hs   = raw_sync(n - g.sd, g, 1'b0);
        e.vs   = raw_sync(n - g.sd, g, 1'b1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit ra, input bit rb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        #1;
        na = ra ? 0 : na + 1;
        nb = rb ? 0 : nb + 1;
        qa.push_back(ref_model(na, ga));
        qb.push_back(ref_model(nb, gb));
    endtask

    // Stimulus: reset, a long default-raster run with two mid-frame resets, random resets on the small raster.
    initial begin
        int  a_phase, a_hold, t_a1;
        bit  ra, rb;
        ga = '{cdiv:4, sd:1, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
        gb = '{cdiv:1, sd:0, hv:8, hf:2, hs:3, hb:2, vv:6, vf:1, vs:2, vb:2};
        a_phase = 0;
        a_hold  = 0;
        t_a1    = 4 * (800 * 11 + $urandom_range(100, 799) + 1) + $urandom_range(0, 3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int c = 0; c < 60000; c++) begin
            if (a_hold > 0) begin
                ra = 1'b1;
                a_hold--;
            end else if ((a_phase == 0 && na == t_a1) || (a_phase == 1 && na == 17204)) begin
                ra = 1'b1;
                a_hold = $urandom_range(0, 2);
                a_phase++;
            end else begin
                ra = 1'b0;
            end
            rb = ($urandom_range(0, 2999) == 0);
            step(ra, rb);
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        #20;
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        chk("a_resets_issued", a_phase, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: every cycle both instances present a raster sample; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (qa.size() == 0) begin
                chk("a_expect_missing", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_row", row_a, e.row);
                chk("a_line", line_a, e.line);
                chk("a_enable", en_a, e.en);
                chk("a_hsync", hs_a, e.hs);
                chk("a_vsync", vs_a, e.vs);
                chk("a_tick", tick_a, e.tick);
                chk("a_frame_start", fs_a, e.fs);
            end
            if (qb.size() == 0) begin
                chk("b_expect_missing", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_row", row_b, e.row);
                chk("b_line", line_b, e.line);
                chk("b_enable", en_b, e.en);
                chk("b_hsync", hs_b, e.hs);
                chk("b_vsync", vs_b, e.vs);
                chk("b_tick", tick_b, e.tick);
                chk("b_frame_start", fs_b, e.fs);
            end
        end
    end

endmodule
